// File: rtl/fifo_drain_pkg.sv
// Shared types and sizing for the FIFO burst-drain block.
package fifo_drain_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned MAX_DATA       = 16;
  localparam int unsigned CNT_W          = $clog2(MAX_DATA + 1);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } drain_state_t;

endpackage

// File: rtl/drain_out_reg.sv
// Output register slice: holds one beat until the downstream accepts it.
module drain_out_reg
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              slot_free
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      last_q  <= load_last;
    end else if (valid_q && m_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign m_last    = last_q;
  assign slot_free = !valid_q || m_ready;

endmodule

// File: rtl/fifo_burst_drain.sv
// Pops the byte FIFO in full bursts, or flushes a partial burst after an idle timeout.
module fifo_burst_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_ren,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              flush_pulse
);

  localparam int unsigned        WAIT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]   BURST_C   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]   ONE_BEAT  = CNT_W'(1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX  = '1;

  drain_state_t      state_q, state_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic              flush_q, flush_d;
  logic              slot_free;
  logic              pop;

  assign pop = !rst && (state_q != IDLE) && (beats_q != '0) && !fifo_empty && slot_free;

  assign fifo_ren    = pop;
  assign busy        = (state_q != IDLE);
  assign flush_pulse = flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beats_q <= '0;
      wait_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    flush_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fifo_count >= BURST_C) begin
          state_d = BURST;
          beats_d = BURST_C;
          wait_d  = '0;
        end else if (!fifo_empty && (wait_q == WAIT_LAST)) begin
          state_d = FLUSH;
          beats_d = fifo_count;
          wait_d  = '0;
          flush_d = 1'b1;
        end else if (!fifo_empty) begin
          if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
        end else begin
          wait_d = '0;
        end
      end
      BURST, FLUSH: begin
        // A zero-length flush (count disagreeing with empty) must not lock the block up.
        if (beats_q == '0) begin
          state_d = IDLE;
        end else if (pop) begin
          beats_d = beats_q - 1'b1;
          if (beats_q == ONE_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  drain_out_reg #(
    .DATA_W(DATA_W)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (pop),
    .load_data(fifo_rdata),
    .load_last(beats_q == ONE_BEAT),
    .m_ready  (m_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .slot_free(slot_free)
  );

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Scoreboard bench for fifo_burst_drain with a queue-based FIFO and drain reference model.
module tb_fifo_burst_drain;
  import fifo_drain_pkg::*;

  localparam int BL = 4;
  localparam int TO = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             fifo_ren;
  logic             m_valid;
  logic             m_ready;
  logic [7:0]       m_data;
  logic             m_last;
  logic             busy;
  logic             flush_pulse;

  always #5 clk = ~clk;

  fifo_burst_drain #(
    .DATA_W   (8),
    .BURST_LEN(BL),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .flush_pulse(flush_pulse)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  byte unsigned fifo_q[$];
  byte unsigned wr_q[$];
  beat_t       exp_q[$];
  bit          rst_v = 1'b1;
  bit          rdy_v = 1'b1;
  bit          chk_en = 1'b0;
  bit          pop_pend = 1'b0;

  // Reference model: burst in progress, beats remaining, idle timer, output slot occupancy.
  bit md_active = 1'b0;
  bit md_slot   = 1'b0;
  bit md_flush  = 1'b0;
  int md_left   = 0;
  int md_wait   = 0;

  int cyc       = 0;
  int ne_cyc    = -1;
  int flush_cyc = -1;
  int acc_cnt   = 0;
  bit prev_ne   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    rst        = rst_v;
    m_ready    = rdy_v;
    fifo_count = CNT_W'(fifo_q.size());
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic model_step();
    int n;
    bit exp_ren;
    bit acc;
    bit nf;
    n = fifo_q.size();
    cyc++;
    if (n != 0 && !prev_ne) ne_cyc = cyc;
    prev_ne = (n != 0);
    if (flush_pulse === 1'b1) flush_cyc = cyc;
    exp_ren = !rst && md_active && (md_left > 0) && (n > 0) && (!md_slot || m_ready);
    if (chk_en) begin
      check("fifo_ren", fifo_ren, exp_ren);
      check("m_valid", m_valid, md_slot);
      check("busy", busy, md_active);
      check("flush_pulse", flush_pulse, md_flush);
      check("no_underflow", fifo_ren && (n == 0), 0);
    end
    pop_pend = (fifo_ren === 1'b1) && (n > 0);
    if (rst) begin
      if (md_slot && !m_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      md_active = 0; md_slot = 0; md_flush = 0; md_left = 0; md_wait = 0;
    end else begin
      acc = md_slot && m_ready;
      nf  = 0;
      if (!md_active) begin
        if (n >= BL) begin
          md_active = 1; md_left = BL; md_wait = 0;
        end else if (n > 0 && md_wait == TO - 1) begin
          md_active = 1; md_left = n; md_wait = 0; nf = 1;
        end else if (n > 0) begin
          if (md_wait < 31) md_wait++;
        end else begin
          md_wait = 0;
        end
        if (acc) md_slot = 0;
      end else if (exp_ren) begin
        exp_q.push_back('{d: fifo_q[0], l: (md_left == 1)});
        md_left--;
        md_slot = 1;
        if (md_left == 0) md_active = 0;
      end else if (acc) begin
        md_slot = 0;
      end
      md_flush = nf;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && m_valid === 1'b1 && m_ready === 1'b1) begin
      acc_cnt++;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", m_data, e.d);
        check("beat_last", m_last, e.l);
      end
    end
  end

  task automatic neg();
    @(negedge clk);
    #1;
    model_step();
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
    if (pop_pend) void'(fifo_q.pop_front());
    pop_pend = 1'b0;
    while (wr_q.size() > 0) begin
      if (fifo_q.size() < MAX_DATA) fifo_q.push_back(wr_q.pop_front());
      else void'(wr_q.pop_front());
    end
    chk_en = 1'b1;
    drive();
  endtask

  task automatic tick();
    neg();
    pos();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns just after the negedge on which the accept count reaches target.
  task automatic wait_acc(input int target, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      neg();
      if (acc_cnt >= target) hit = 1;
      else pos();
    end
    check("wait_acc", hit, 1);
    if (!hit) neg();
  endtask

  task automatic settle();
    bit done;
    done = 0;
    for (int i = 0; i < 80 && !done; i++) begin
      if (fifo_q.size() == 0 && !md_active && !md_slot && exp_q.size() == 0) done = 1;
      else tick();
    end
    check("settle", done, 1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 5; i++) fifo_q.push_back(byte'(8'h51 + i));
    drive();

    // Reset held two cycles with five entries present, then release.
    tick();
    tick();
    rst_v = 1'b0;
    run(30);
    settle();

    // Full burst.
    wr_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    run(10);
    settle();

    // Backpressure after the first beat is taken: 0x12 is held for three cycles.
    base = acc_cnt;
    wr_q = '{8'h11, 8'h12, 8'h13, 8'h14};
    wait_acc(base + 1, 20);
    rdy_v = 1'b0;
    pos();
    tick();
    tick();
    neg();
    check("bp_hold_data", m_data, 8'h12);
    check("bp_hold_valid", m_valid, 1);
    check("bp_hold_ren", fifo_ren, 0);
    rdy_v = 1'b1;
    pos();
    run(8);
    settle();

    // Timeout flush of a two-entry partial burst.
    flush_cyc = -1;
    wr_q = '{8'hA0, 8'hA1};
    run(25);
    check("flush_delay", flush_cyc - ne_cyc, 15);
    settle();

    // Reset in the middle of a burst.
    base = acc_cnt;
    wr_q = '{8'h31, 8'h32, 8'h33, 8'h34};
    wait_acc(base + 2, 20);
    rst_v = 1'b1;
    pos();
    rst_v = 1'b0;
    tick();
    neg();
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ren", fifo_ren, 0);
    pos();
    run(30);
    settle();

    // Two back-to-back bursts.
    wr_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run(20);
    settle();

    // Randomized traffic, backpressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rdy_v = ($urandom_range(0, 9) < 7);
      rst_v = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++)
          if (fifo_q.size() + wr_q.size() < MAX_DATA) wr_q.push_back(byte'($urandom_range(0, 255)));
      end
      tick();
    end
    rst_v = 1'b0;
    rdy_v = 1'b1;
    tick();
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_burst_drain.md
Name: fifo_burst_drain

Overview:
- Downstream consumer of the 16-entry byte FIFO.
- Pops FIFO contents in bursts and presents them as a valid/ready byte stream with an end-of-burst marker.
- Starts a full burst once BURST_LEN entries are available, or flushes a partial burst after the FIFO has been non-empty for TIMEOUT idle cycles.
- Single owner of the FIFO read side (ren); the FIFO's async read data is registered here.

Parameters:
- DATA_W, 8, stream/FIFO data width.
- MAX_DATA, 16, FIFO depth; count width CNT_W = $clog2(MAX_DATA+1) = 5.
- BURST_LEN, 4, beats per full burst; legal range 1..MAX_DATA.
- TIMEOUT, 15, idle cycles with partial data before a flush; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous active-high.
- fifo_count  in  CNT_W  FIFO occupancy.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DATA_W  FIFO head data, asynchronous read.
- fifo_ren  out  1  pop request; combinational.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  output beat.
- m_last  out  1  final beat of the current burst.
- busy  out  1  state != IDLE.
- flush_pulse  out  1  one-cycle pulse on entering FLUSH.

Behaviour:
- Reset (synchronous, active-high, one clock):
  - state=IDLE; beats_left=0; wait_cnt=0.
  - m_valid=0, m_data=0, m_last=0, flush_pulse=0.
  - Any held beat is discarded.
  - fifo_ren=0 while rst is high.
- States: IDLE, BURST, FLUSH.
- IDLE transitions, in priority order:
  - fifo_count >= BURST_LEN -> BURST; load beats_left=BURST_LEN; clear wait_cnt.
  - Else if !fifo_empty and wait_cnt == TIMEOUT-1 -> FLUSH; load beats_left=fifo_count; clear wait_cnt; flush_pulse=1 next cycle.
  - Else if !fifo_empty -> wait_cnt++.
  - Else (empty) -> wait_cnt=0.
- Pop condition: fifo_ren = (state != IDLE) && beats_left != 0 && !fifo_empty && (!m_valid || m_ready).
- On a pop edge:
  - m_data <= fifo_rdata; m_valid <= 1.
  - m_last <= (beats_left == 1).
  - beats_left--.
  - If beats_left was 1, state <= IDLE on the same edge.
- No pop while m_valid && m_ready: m_valid <= 0 on that edge.
- While m_valid && !m_ready: m_data and m_last held stable; fifo_ren=0.
- Latency:
  - fifo_count reaches BURST_LEN in cycle t -> BURST and first fifo_ren in cycle t+1 -> m_valid in t+2.
  - Steady state 1 beat/cycle with m_ready=1.
- Back-to-back bursts:
  - IDLE evaluates fifo_count in the cycle after the last pop, so there is one bubble cycle between bursts.
  - The final beat of the previous burst may still be pending.
- Empty mid-burst cannot occur with a single reader; if it does, the block stalls (fifo_ren=0) without leaving the state.
- Guarantees:
  - fifo_ren is never asserted while fifo_empty=1.
  - No underflow, no dropped or duplicated beats.
- Upstream writes while the FIFO is full are outside this block's contract.
- wait_cnt width is $clog2(TIMEOUT)+1; it saturates and never wraps.

Decomposition:
- Package fifo_drain_pkg holds:
  - typedef enum logic [1:0] {IDLE, BURST, FLUSH} drain_state_t;
  - localparam CNT_W and the default DATA_W.
- One sub-module, drain_out_reg: the output register slice.
  - Inputs: load, load_data, load_last, m_ready.
  - Outputs: m_valid, m_data, m_last, slot_free.
  - The top FSM uses slot_free in the pop condition.

Test Plan:
- Reset: drive rst=1 for 2 cycles with fifo_count=5 -> m_valid=0, fifo_ren=0, busy=0 throughout; on rst release, BURST begins the next cycle.
- Full burst: FIFO holds 0x11,0x12,0x13,0x14, m_ready=1 -> fifo_ren high for 4 consecutive cycles; m_data=11,12,13,14 on consecutive cycles; m_last=1 only with 0x14; busy falls after the 4th pop.
- Backpressure: same data, m_ready=0 for 3 cycles after the 2nd beat -> m_data=0x12 held, fifo_ren=0, no loss; the remaining beats 13,14 follow once m_ready=1.
- Timeout flush: FIFO holds 0xA0,0xA1 with no further writes -> flush_pulse 15 cycles after non-empty is observed; beats A0, A1 with m_last on A1.
- Mid-burst reset: rst=1 after 2 of 4 beats -> next edge m_valid=0, busy=0, fifo_ren=0; the 2 remaining entries are drained by a later flush or burst.
- Two bursts: 8 entries 0x00..0x07 -> two 4-beat bursts with m_last on 0x03 and 0x07, one bubble cycle between them.
